pack32_64: RTL and testbench
============================

Name: pack32_64

Overview:
- Write-side gearbox that assembles consecutive DATA_W-bit words into one 2*DATA_W-bit word, with valid/ready handshakes on both sides.
- Sits in front of the datapath's 64-to-32 half-select muxes. Select=0 on the packed word yields the first accepted word; select=1 yields the second.
- Supports early flush of a lone word via in_last. Missing halves are zero-padded and flagged in out_keep.

Parameters:
- DATA_W, 32, width of each input word; the output is 2*DATA_W.
- FIRST_LOW, 1, 1 = first word goes to out_data[DATA_W-1:0]; 0 = first word goes to the upper half.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_data  input  DATA_W  input word.
- in_valid  input  1  in_data is valid.
- in_last  input  1  this word ends its group; emit now, padding if it is the first word.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  2*DATA_W  packed word.
- out_keep  output  2  bit0 = first-word half valid; bit1 = second-word half valid.
- out_valid  output  1  out_data/out_keep are valid.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Handshake fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: S_EMPTY (nothing held), S_HALF (first word held), S_FULL (out_valid=1).
- Reset (rst_n=0 at a clk edge): state=S_EMPTY, out_valid=0, out_data=0, out_keep=2'b00, internal hold register=0.
- in_ready is combinational: 0 while rst_n=0; otherwise 1 in S_EMPTY/S_HALF, and out_ready in S_FULL. No combinational path from in_valid to in_ready.
- S_EMPTY:
  - in_fire & !in_last: store the word in the hold register → S_HALF.
  - in_fire & in_last: load out_data = {0, word} (respecting FIRST_LOW), out_keep=01 → S_FULL.
- S_HALF:
  - in_fire: out_data = {word, held} (respecting FIRST_LOW), out_keep=11 → S_FULL. in_last is ignored here because the group is already complete.
- S_FULL:
  - out_data/out_keep are held stable while out_valid & !out_ready.
  - out_fire & !in_fire → S_EMPTY, out_valid=0.
  - out_fire & in_fire: treat the new word as in S_EMPTY (→ S_HALF, or reload S_FULL with keep=01 if in_last). This gives full throughput for single-word groups.
- Latency: out_valid rises on the edge after the completing in_fire (1 cycle).
- Sustained throughput: 1 input word per cycle while out_ready=1 (2-word groups emit every 2 cycles with no stall).
- Padding: unused half is all zeros, never stale data.
- Reset mid-operation: any held half word and any pending output are discarded; nothing is emitted afterwards for the aborted group.
- in_data/in_last are don't-care when in_valid=0. out_data is don't-care-free: it retains its last value when out_valid=0.

Decomposition:
- Shared package holds:
  - state encoding localparams S_EMPTY=2'd0, S_HALF=2'd1, S_FULL=2'd2;
  - KEEP_FIRST=2'b01 and KEEP_BOTH=2'b11;
  - default DATA_W=32.
- One natural sub-module, pack_place, a purely combinational placer. It takes the first word, the second word and FIRST_LOW, and returns the 2*DATA_W vector. It reuses the existing 2:1 mux for the half ordering.
- The FSM, hold register and output register stay in pack32_64.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles → out_valid=0, out_data=0, out_keep=00, in_ready=0. After release, in_ready=1.
- Pair, FIRST_LOW=1: send 0x11111111 then 0x22222222 with out_ready=1 → next cycle out_data=0x22222222_11111111, out_keep=11, out_valid=1 for exactly 1 cycle.
- Lone word with in_last: send 0xDEADBEEF with in_last=1 → out_data=0x00000000_DEADBEEF, out_keep=01.
  - With FIRST_LOW=0: out_data=0xDEADBEEF_00000000.
- Backpressure: complete a pair with out_ready=0 for 3 cycles → out_data stable and in_ready=0 throughout. Raise out_ready while offering 0xA5A5A5A5 → both fire in the same cycle; state S_HALF holds 0xA5A5A5A5.
- Streaming: 8 words 0..7 with in_valid=1 and out_ready=1 → outputs 0x1_0, 0x3_2, 0x5_4, 0x7_6 on consecutive even cycles, no stall. Then 4 back-to-back in_last words → 4 outputs on 4 consecutive cycles, each keep=01.
- Reset mid-group: accept 0x12345678 (S_HALF), assert rst_n=0 for 1 cycle, then send 0xCAFEF00D + 0x0BADBEEF → output 0x0BADBEEF_CAFEF00D; 0x12345678 never appears.

Source files
------------

// File: rtl/pack32_64_pkg.sv
// Shared definitions for the pack32_64 gearbox: state encoding, keep patterns
// and the default word width.
package pack32_64_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] KEEP_FIRST = 2'b01;
  localparam logic [1:0] KEEP_BOTH  = 2'b11;

endpackage

// File: rtl/pack32_64_place.sv
// Places the first and second word into the packed output, honouring which
// half the first word occupies.
module pack_place #(
  parameter int DATA_W = 32
) (
  input  logic                  first_low,
  input  logic [DATA_W-1:0]     first,
  input  logic [DATA_W-1:0]     second,
  output logic [2*DATA_W-1:0]   packed_word
);

  assign packed_word = first_low ? {second, first} : {first, second};

endmodule

// File: rtl/pack32_64.sv
// Two-to-one word gearbox: pairs consecutive DATA_W words into one 2*DATA_W
// word, with early flush of a lone word via in_last (missing half zeroed).
module pack32_64
  import pack32_64_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FIRST_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [1:0]            out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t                state;
  logic [DATA_W-1:0]     hold_p0;
  logic [2*DATA_W-1:0]   lone_word;
  logic [2*DATA_W-1:0]   pair_word;
  logic [DATA_W-1:0]     zero_word;
  logic                  in_fire;
  logic                  out_fire;

  assign zero_word = '0;

  // in_ready depends only on state, out_ready and reset, never on in_valid.
  assign in_ready = rst_n & ((state != S_FULL) | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  pack_place #(.DATA_W(DATA_W)) u_place_lone (
    .first_low   (FIRST_LOW != 0),
    .first       (in_data),
    .second      (zero_word),
    .packed_word (lone_word)
  );

  pack_place #(.DATA_W(DATA_W)) u_place_pair (
    .first_low   (FIRST_LOW != 0),
    .first       (hold_p0),
    .second      (in_data),
    .packed_word (pair_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      hold_p0   <= '0;
      out_data  <= '0;
      out_keep  <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (in_fire) begin
            if (in_last) begin
              out_data  <= lone_word;
              out_keep  <= KEEP_FIRST;
              out_valid <= 1'b1;
              state     <= S_FULL;
            end else begin
              hold_p0 <= in_data;
              state   <= S_HALF;
            end
          end
        end
        S_HALF: begin
          if (in_fire) begin
            out_data  <= pair_word;
            out_keep  <= KEEP_BOTH;
            out_valid <= 1'b1;
            state     <= S_FULL;
          end
        end
        S_FULL: begin
          // in_fire here implies out_fire, so the new word starts a fresh group.
          if (out_fire) begin
            if (in_fire && in_last) begin
              out_data  <= lone_word;
              out_keep  <= KEEP_FIRST;
              out_valid <= 1'b1;
              state     <= S_FULL;
            end else if (in_fire) begin
              hold_p0   <= in_data;
              out_valid <= 1'b0;
              state     <= S_HALF;
            end else begin
              out_valid <= 1'b0;
              state     <= S_EMPTY;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pack32_64.sv
// Directed bench for pack32_64: one instance per half ordering, driven from
// shared inputs and checked against hand-computed values.
module tb_pack32_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_lo, in_ready_hi;
  logic [63:0] out_data_lo, out_data_hi;
  logic [1:0]  out_keep_lo, out_keep_hi;
  logic        out_valid_lo, out_valid_hi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pack32_64 #(.DATA_W(32), .FIRST_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_lo), .out_data(out_data_lo),
    .out_keep(out_keep_lo), .out_valid(out_valid_lo), .out_ready(out_ready)
  );

  pack32_64 #(.DATA_W(32), .FIRST_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_hi), .out_data(out_data_hi),
    .out_keep(out_keep_hi), .out_valid(out_valid_hi), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid_lo, 0);
    chk("rst_data",  out_data_lo, 0);
    chk("rst_keep",  out_keep_lo, 0);
    chk("rst_ready", in_ready_lo, 0);
    rst_n = 1'b1; #1;
    chk("rel_ready", in_ready_lo, 1);

    // pair with FIRST_LOW=1
    out_ready = 1'b1;
    drive(32'h1111_1111, 1'b0); tick();
    drive(32'h2222_2222, 1'b0); tick();
    in_valid = 1'b0;
    chk("pair_valid", out_valid_lo, 1);
    chk("pair_data",  out_data_lo, 64'h2222_2222_1111_1111);
    chk("pair_keep",  out_keep_lo, 2'b11);
    chk("pair_hi_data", out_data_hi, 64'h1111_1111_2222_2222);
    tick();
    chk("pair_1cyc", out_valid_lo, 0);
    chk("pair_retain", out_data_lo, 64'h2222_2222_1111_1111);

    // lone word flushed by in_last
    drive(32'hDEAD_BEEF, 1'b1); tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("lone_data_lo", out_data_lo, 64'h0000_0000_DEAD_BEEF);
    chk("lone_keep_lo", out_keep_lo, 2'b01);
    chk("lone_data_hi", out_data_hi, 64'hDEAD_BEEF_0000_0000);
    chk("lone_keep_hi", out_keep_hi, 2'b01);
    tick();
    chk("lone_drain", out_valid_lo, 0);

    // backpressure
    out_ready = 1'b0;
    drive(32'h3333_3333, 1'b0); tick();
    drive(32'h4444_4444, 1'b0); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", in_ready_lo, 0);
      chk("bp_valid", out_valid_lo, 1);
      chk("bp_data",  out_data_lo, 64'h4444_4444_3333_3333);
      tick();
    end
    out_ready = 1'b1;
    drive(32'hA5A5_A5A5, 1'b0); #1;
    chk("bp_release_ready", in_ready_lo, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_after_valid", out_valid_lo, 0);
    drive(32'hB6B6_B6B6, 1'b0); tick();
    in_valid = 1'b0;
    chk("bp_held_data", out_data_lo, 64'hB6B6_B6B6_A5A5_A5A5);
    chk("bp_held_keep", out_keep_lo, 2'b11);
    tick();

    // streaming pairs, then back-to-back single-word groups
    for (int i = 0; i < 8; i++) begin
      drive(32'(i), 1'b0);
      chk("st_ready", in_ready_lo, 1);
      tick();
      if (i % 2 == 1) begin
        chk("st_valid", out_valid_lo, 1);
        chk("st_data",  out_data_lo, {32'(i), 32'(i - 1)});
      end else begin
        chk("st_gap", out_valid_lo, 0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(32'h100 + 32'(k), 1'b1);
      tick();
      chk("sl_valid", out_valid_lo, 1);
      chk("sl_data",  out_data_lo, {32'h0, 32'h100 + 32'(k)});
      chk("sl_keep",  out_keep_lo, 2'b01);
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();

    // reset mid-group discards the held word
    drive(32'h1234_5678, 1'b0); tick();
    in_valid = 1'b0;
    rst_n = 1'b0; tick();
    chk("mid_rst_valid", out_valid_lo, 0);
    chk("mid_rst_ready", in_ready_lo, 0);
    rst_n = 1'b1;
    drive(32'hCAFE_F00D, 1'b0); tick();
    chk("mid_no_emit", out_valid_lo, 0);
    drive(32'h0BAD_BEEF, 1'b0); tick();
    in_valid = 1'b0;
    chk("mid_data_lo", out_data_lo, 64'h0BAD_BEEF_CAFE_F00D);
    chk("mid_data_hi", out_data_hi, 64'hCAFE_F00D_0BAD_BEEF);
    chk("mid_keep",    out_keep_lo, 2'b11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
